// File: rtl/inst_fetch_if.sv
// +----------------------------------------------------------------------+
// | inst_fetch_if : ROM read port, branch redirect and decode handshake   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface inst_fetch_if #(
  parameter int LEN_ADDR = 32,
  parameter int LEN_DATA = 32
);
  logic                rom_ce;
  logic [LEN_ADDR-1:0] rom_addr;
  logic [LEN_DATA-1:0] rom_data;
  logic                branch_en;
  logic [LEN_ADDR-1:0] branch_target;
  logic                inst_valid;
  logic [LEN_DATA-1:0] inst;
  logic [LEN_ADDR-1:0] inst_pc;
  logic                inst_ready;

  modport master (
    output rom_ce, rom_addr, inst_valid, inst, inst_pc,
    input  rom_data, branch_en, branch_target, inst_ready
  );

  modport slave (
    input  rom_ce, rom_addr, inst_valid, inst, inst_pc,
    output rom_data, branch_en, branch_target, inst_ready
  );
endinterface

`default_nettype wire

// File: rtl/inst_fetch.sv
// +----------------------------------------------------------------------+
// | inst_fetch : PC owner, ROM fetch, 2-entry buffer to decode            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module inst_fetch #(
  parameter int                  LEN_ADDR = 32,
  parameter int                  LEN_DATA = 32,
  parameter logic [LEN_ADDR-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);

  localparam logic [LEN_ADDR-1:0] c_STEP = LEN_ADDR'(4);

  logic                r_ce;
  logic [LEN_ADDR-1:0] r_pc;
  logic [1:0]          r_count;
  logic [LEN_ADDR-1:0] r_head_pc;
  logic [LEN_DATA-1:0] r_head_word;
  logic [LEN_ADDR-1:0] r_tail_pc;
  logic [LEN_DATA-1:0] r_tail_word;

  logic                w_pop;
  logic                w_accept;
  logic [LEN_ADDR-1:0] w_target;
  logic                w_unused_target_lsbs;

  always_comb begin
    w_pop    = (r_count != 2'd0) && bus.inst_ready;
    w_accept = r_ce && !bus.branch_en && ((r_count != 2'd2) || w_pop);
    w_target = {bus.branch_target[LEN_ADDR-1:2], 2'b00};
  end

  assign w_unused_target_lsbs = ^bus.branch_target[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce        <= 1'b0;
      r_pc        <= RESET_PC;
      r_count     <= 2'd0;
      r_head_pc   <= '0;
      r_head_word <= '0;
      r_tail_pc   <= '0;
      r_tail_word <= '0;
    end else begin
      r_ce <= 1'b1;
      if (bus.branch_en) begin
        // Redirect drops everything in flight, including a same-cycle pop.
        r_count <= 2'd0;
        r_pc    <= w_target;
      end else begin
        if (w_accept) begin
          r_pc <= r_pc + c_STEP;
        end
        case ({w_accept, w_pop})
          2'b10: begin
            if (r_count == 2'd0) begin
              r_head_pc   <= r_pc;
              r_head_word <= bus.rom_data;
            end else begin
              r_tail_pc   <= r_pc;
              r_tail_word <= bus.rom_data;
            end
            r_count <= r_count + 2'd1;
          end
          2'b01: begin
            r_head_pc   <= r_tail_pc;
            r_head_word <= r_tail_word;
            r_count     <= r_count - 2'd1;
          end
          2'b11: begin
            // Occupancy unchanged: full buffer shifts, single entry is replaced.
            if (r_count == 2'd2) begin
              r_head_pc   <= r_tail_pc;
              r_head_word <= r_tail_word;
              r_tail_pc   <= r_pc;
              r_tail_word <= bus.rom_data;
            end else begin
              r_head_pc   <= r_pc;
              r_head_word <= bus.rom_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rom_ce     = r_ce;
  assign bus.rom_addr   = r_pc;
  assign bus.inst_valid = (r_count != 2'd0);
  assign bus.inst       = r_head_word;
  assign bus.inst_pc    = r_head_pc;

endmodule

`default_nettype wire
